// File: rtl/dp_accum.sv
// Accumulates per-precision SIMD dot-product sums over a programmed number of beats
// and hands the total downstream. Define DP_ACC_SAT_EN to saturate instead of wrap.
module dp_accum #(
    parameter int ACC_W = 48,   // must be >= 35 to hold a single int16 sum
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [34:0]      sum_int16,
    input  logic [18:0]      sum_int8,
    input  logic [11:0]      sum_int4,
    input  logic [10:0]      sum_int2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic             busy,
    output logic             ovf
);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    typedef struct packed {
        logic [1:0]       mode;
        logic [CNT_W-1:0] len;
    } job_t;

    state_t           state, state_d;
    job_t             job_q;
    logic [ACC_W-1:0] acc, acc_nxt, out_acc_q;
    logic [CNT_W-1:0] cnt, cnt_inc;
    logic [34:0]      sel;
    logic [ACC_W:0]   sum_w;
    logic             carry, accept, last_beat, load, ack;
    logic             ovf_q, out_valid_q;

    // Only the latched mode steers the mux, so mid-job mode changes are harmless.
    always_comb begin
        sel = '0;
        case (job_q.mode)
            2'd0:    sel = 35'(sum_int2);
            2'd1:    sel = 35'(sum_int4);
            2'd2:    sel = 35'(sum_int8);
            default: sel = sum_int16;
        endcase
    end

    assign sum_w = {1'b0, acc} + {1'b0, ACC_W'(sel)};
    assign carry = sum_w[ACC_W];

`ifdef DP_ACC_SAT_EN
    // Once pinned at all-ones, any further non-zero beat carries again and re-pins.
    assign acc_nxt = carry ? '1 : sum_w[ACC_W-1:0];
`else
    assign acc_nxt = sum_w[ACC_W-1:0];
`endif

    assign cnt_inc   = cnt + CNT_W'(1);
    assign load      = (state == IDLE) && start;
    assign accept    = (state == ACCUM) && in_valid;
    assign last_beat = accept && (cnt_inc == job_q.len);
    assign ack       = (state == DONE) && out_ready;

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (start) state_d = (len == '0) ? DONE : ACCUM;
            ACCUM:   if (last_beat) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state <= IDLE;
        else       state <= state_d;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            job_q       <= '0;
            acc         <= '0;
            cnt         <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_acc_q   <= '0;
        end else if (load) begin
            job_q <= '{mode: mode, len: len};
            acc   <= '0;
            cnt   <= '0;
            ovf_q <= 1'b0;
            if (len == '0) begin
                out_valid_q <= 1'b1;
                out_acc_q   <= '0;
            end
        end else if (accept) begin
            acc <= acc_nxt;
            cnt <= cnt_inc;
            if (carry) ovf_q <= 1'b1;
            // Result is captured on the accepting edge so out_valid has 1-cycle latency.
            if (last_beat) begin
                out_valid_q <= 1'b1;
                out_acc_q   <= acc_nxt;
            end
        end else if (ack) begin
            out_valid_q <= 1'b0;
        end
    end

    assign in_ready  = (state == ACCUM);
    assign busy      = (state != IDLE);
    assign out_valid = out_valid_q;
    assign out_acc   = out_acc_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_dp_accum.sv
// Directed plus randomized jobs against a sum-of-selected-values reference model.
module tb_dp_accum;

    localparam int ACC_W = 36;
    localparam int CNT_W = 8;
    localparam longint unsigned MASK = (64'd1 << ACC_W) - 1;

    logic             clk = 1'b0;
    logic             nrst, start, in_valid, in_ready, out_valid, out_ready, busy, ovf;
    logic [1:0]       mode;
    logic [CNT_W-1:0] len;
    logic [34:0]      s16;
    logic [18:0]      s8;
    logic [11:0]      s4;
    logic [10:0]      s2;
    logic [ACC_W-1:0] out_acc;

    int n_chk = 0;
    int n_fail = 0;

    logic [34:0] f16 [8];
    logic [18:0] f8  [8];
    logic [11:0] f4  [8];
    logic [10:0] f2  [8];
    bit          use_fixed;

    dp_accum #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .nrst(nrst), .start(start), .mode(mode), .len(len),
        .in_valid(in_valid), .in_ready(in_ready),
        .sum_int16(s16), .sum_int8(s8), .sum_int4(s4), .sum_int2(s2),
        .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc),
        .busy(busy), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic rnd_sums();
        s16 = {3'($urandom), $urandom};
        s8  = 19'($urandom);
        s4  = 12'($urandom);
        s2  = 11'($urandom);
    endtask

    task automatic fill_fixed();
        for (int i = 0; i < 8; i++) begin
            f16[i] = {3'($urandom), $urandom};
            f8[i]  = 19'($urandom);
            f4[i]  = 12'($urandom);
            f2[i]  = 11'($urandom);
        end
    endtask

    // One complete job: start, beats (with optional gaps), backpressured result, ack.
    task automatic do_job(input logic [1:0] m, input int n, input int gap, input int bp,
                          input bit ign);
        longint unsigned total = 0;
        longint unsigned v;
        logic [63:0]     exp_acc;
        logic            exp_ovf;
        int              g;
        start = 1'b1; mode = m; len = CNT_W'(n);
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("ovf_cleared_at_start", ovf, 0);
        chk("in_ready_after_start", in_ready, n != 0);
        chk("out_valid_after_start", out_valid, n == 0);
        for (int b = 0; b < n; b++) begin
            g = (gap < 0) ? int'($urandom_range(0, 2)) : ((b == 1) ? gap : 0);
            repeat (g) begin
                in_valid = 1'b0;
                rnd_sums();
                @(negedge clk);
                chk("in_ready_in_gap", in_ready, 1);
                chk("out_valid_in_gap", out_valid, 0);
            end
            if (use_fixed && b < 8) begin
                s16 = f16[b]; s8 = f8[b]; s4 = f4[b]; s2 = f2[b];
            end else begin
                rnd_sums();
            end
            in_valid = 1'b1;
            case (m)
                2'd0:    v = s2;
                2'd1:    v = s4;
                2'd2:    v = s8;
                default: v = s16;
            endcase
            total += v;
            if (ign && b == 0) begin
                start = 1'b1; mode = ~m; len = CNT_W'(n + 1);
            end
            @(negedge clk);
            start = 1'b0; in_valid = 1'b0;
            mode = 2'($urandom);
            chk("out_valid_after_beat", out_valid, b == n - 1);
            chk("in_ready_after_beat", in_ready, b != n - 1);
        end
        exp_ovf = (total > MASK);
`ifdef DP_ACC_SAT_EN
        exp_acc = exp_ovf ? MASK : total;
`else
        exp_acc = total & MASK;
`endif
        chk("out_valid_result", out_valid, 1);
        chk("out_acc_result", out_acc, exp_acc);
        chk("ovf_result", ovf, exp_ovf);
        chk("in_ready_in_done", in_ready, 0);
        for (int i = 0; i < bp; i++) begin
            out_ready = 1'b0;
            if (ign && i == 0) begin
                start = 1'b1; mode = ~m; len = CNT_W'(n + 2);
            end
            @(negedge clk);
            start = 1'b0;
            chk("out_valid_held", out_valid, 1);
            chk("out_acc_held", out_acc, exp_acc);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("out_valid_after_ack", out_valid, 0);
        chk("busy_after_ack", busy, 0);
    endtask

    initial begin
        nrst = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        mode = '0; len = '0; s16 = '0; s8 = '0; s4 = '0; s2 = '0;
        use_fixed = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_out_acc", out_acc, 0);
        nrst = 1'b1;
        @(negedge clk);

        // Reset mid-job discards the partial sum
        start = 1'b1; mode = 2'd3; len = 8'd4;
        @(negedge clk);
        start = 1'b0; s16 = 35'd100; in_valid = 1'b1;
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        #2 nrst = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_out_acc", out_acc, 0);
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        chk("midrst_stays_idle", busy, 0);
        use_fixed = 1'b1;
        fill_fixed(); f16[0] = 35'd5;
        do_job(2'd3, 1, 0, 0, 1'b0);

        // int8 with an input gap and output backpressure
        fill_fixed(); f8[0] = 19'd10; f8[1] = 19'd20; f8[2] = 19'd30;
        do_job(2'd2, 3, 2, 3, 1'b0);

        // Mode selection ignores the other sum inputs
        fill_fixed(); f2[0] = 11'd7; f2[1] = 11'd7; f16[0] = 35'd1000; f16[1] = 35'd1000;
        do_job(2'd0, 2, 0, 0, 1'b0);
        fill_fixed(); f4[0] = 12'd4095; f4[1] = 12'd4095;
        do_job(2'd1, 2, 0, 1, 1'b0);

        // Zero-length job
        do_job(2'd2, 0, 0, 1, 1'b0);

        // Overflow past 2^36, then ovf must clear on the following start
        fill_fixed();
        for (int i = 0; i < 3; i++) f16[i] = 35'h7_FFFF_FFFF;
        do_job(2'd3, 3, 0, 1, 1'b0);
        do_job(2'd1, 1, 0, 0, 1'b0);

        // start pulsed in ACCUM and DONE must be ignored
        fill_fixed();
        do_job(2'd2, 4, 1, 2, 1'b1);

        // Maximum length exercises the beat counter end point
        use_fixed = 1'b0;
        do_job(2'd0, 255, 0, 0, 1'b0);

        for (int j = 0; j < 25; j++)
            do_job(2'($urandom), int'($urandom_range(0, 6)), -1,
                   int'($urandom_range(0, 3)), 1'($urandom));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
